// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter, drives the fetch handshake, selects the
// next PC (sequential / branch / call / return / IRQ) and keeps a small return stack.
module pc_sequencer #(
    parameter int unsigned      PC_W      = 11,
    parameter logic [PC_W-1:0]  RESET_VEC = '0,
    parameter logic [PC_W-1:0]  IRQ_VEC   = PC_W'(11'h7F0),
    parameter int unsigned      RS_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    output logic            instr_valid,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            call,
    input  logic            ret,
    input  logic            halt,
    input  logic            resume,
    input  logic            irq,
    output logic            irq_ack,
    output logic [PC_W-1:0] pc,
    output logic            rs_err
);

    localparam int unsigned SP_W  = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RS_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ISSUE  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    pc_inc, seq_pc, push_val, rs_top;
    logic               irq_ack_d, push, pop;
    logic [SP_W-1:0]    sp_q, sp_dec;
    logic [CNT_W-1:0]   cnt_q;
    logic [PC_W-1:0]    rs_mem [RS_DEPTH];
    logic               rs_empty, rs_full;

    assign pc_inc    = pc_q + PC_W'(1);
    assign sp_dec    = sp_q - SP_W'(1);
    assign rs_top    = rs_mem[sp_dec];
    assign rs_empty  = (cnt_q == '0);
    assign rs_full   = (cnt_q == CNT_W'(RS_DEPTH));
    assign imem_addr = pc_q;
    assign pc        = pc_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, next PC and return-stack requests
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        irq_ack_d = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        push_val  = pc_inc;
        seq_pc    = br_taken ? br_target : pc_inc;
        case (state_q)
            S_IDLE: state_d = S_WAIT;
            S_WAIT: begin
                if (imem_ack) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (!stall) begin
                    state_d = halt ? S_HALTED : S_WAIT;
                    if (call) begin
                        push     = 1'b1;
                        push_val = pc_inc;
                        pc_d     = br_target;
                    end else if (ret) begin
                        pop  = 1'b1;
                        pc_d = rs_empty ? pc_inc : rs_top;
                    end else if (irq) begin
                        // interrupt returns to wherever this slot would have gone
                        push      = 1'b1;
                        push_val  = seq_pc;
                        pc_d      = IRQ_VEC;
                        irq_ack_d = 1'b1;
                        state_d   = S_WAIT;
                    end else begin
                        pc_d = seq_pc;
                    end
                end
            end
            S_HALTED: begin
                if (irq) begin
                    push      = 1'b1;
                    push_val  = pc_q;
                    pc_d      = IRQ_VEC;
                    irq_ack_d = 1'b1;
                    state_d   = S_WAIT;
                end else if (resume) begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // PC and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_VEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            irq_ack     <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            imem_req    <= (state_d == S_WAIT);
            instr_valid <= (state_d == S_ISSUE);
            irq_ack     <= irq_ack_d;
        end
    end

    // Circular return stack: a push when full overwrites the oldest entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q   <= '0;
            cnt_q  <= '0;
            rs_err <= 1'b0;
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                rs_mem[i] <= '0;
            end
        end else if (push) begin
            rs_mem[sp_q] <= push_val;
            sp_q         <= sp_q + SP_W'(1);
            if (rs_full) begin
                rs_err <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (pop) begin
            if (rs_empty) begin
                rs_err <= 1'b1;
            end else begin
                sp_q  <= sp_dec;
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed slots drive control inputs and queue the expected fetch
// addresses; a negedge monitor pops and compares on every accepted fetch.
module tb_pc_sequencer;

    localparam int unsigned PC_W = 11;

    logic            clk;
    logic            rst_n;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic            instr_valid;
    logic            stall;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic            call;
    logic            ret;
    logic            halt;
    logic            resume;
    logic            irq;
    logic            irq_ack;
    logic [PC_W-1:0] pc;
    logic            rs_err;

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [PC_W-1:0] exp_q [$];
    logic [PC_W-1:0] mon_exp;

    pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .instr_valid (instr_valid),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .call        (call),
        .ret         (ret),
        .halt        (halt),
        .resume      (resume),
        .irq         (irq),
        .irq_ack     (irq_ack),
        .pc          (pc),
        .rs_err      (rs_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Fetch monitor: every accepted request must match the oldest queued address
    always @(negedge clk) begin
        if (rst_n && imem_req && imem_ack) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL fetch_addr: unexpected fetch of 0x%03h, none queued", imem_addr);
            end else begin
                mon_exp = exp_q.pop_front();
                if (imem_addr !== mon_exp) begin
                    n_fail++;
                    $display("FAIL fetch_addr: got 0x%03h expected 0x%03h", imem_addr, mon_exp);
                end
            end
        end
    end

    task automatic chk_v(input string name, input logic [PC_W-1:0] act, input logic [PC_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns once a slot is presented
    task automatic wait_issue();
        int n = 0;
        while (instr_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_b("issue_wait", instr_valid, 1'b1);
    endtask

    task automatic step(input string name, input logic c, input logic r, input logic b,
                        input logic h, input logic [PC_W-1:0] tgt,
                        input logic [PC_W-1:0] nxt, input logic fetch);
        wait_issue();
        call      = c;
        ret       = r;
        br_taken  = b;
        halt      = h;
        br_target = tgt;
        if (fetch) exp_q.push_back(nxt);
        @(posedge clk);
        #1;
        call     = 1'b0;
        ret      = 1'b0;
        br_taken = 1'b0;
        halt     = 1'b0;
        chk_v({name, "_pc"}, pc, nxt);
    endtask

    initial begin
        rst_n     = 1'b0;
        imem_ack  = 1'b1;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        call      = 1'b0;
        ret       = 1'b0;
        halt      = 1'b0;
        resume    = 1'b0;
        irq       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_b("rst_req", imem_req, 1'b0);
        chk_b("rst_valid", instr_valid, 1'b0);
        chk_b("rst_irq_ack", irq_ack, 1'b0);
        chk_b("rst_rs_err", rs_err, 1'b0);
        chk_v("rst_pc", pc, 11'h000);

        exp_q.push_back(11'h000);
        rst_n = 1'b1;
        step("seq0", 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 11'h001, 1'b1);
        step("seq1", 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 11'h002, 1'b1);
        step("br_7ff", 1'b0, 1'b0, 1'b1, 1'b0, 11'h7FF, 11'h7FF, 1'b1);
        step("wrap", 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 11'h000, 1'b1);
        chk_b("wrap_rs_err", rs_err, 1'b0);

        // Stall holds the slot; controls asserted during stall must be ignored
        wait_issue();
        stall     = 1'b1;
        br_taken  = 1'b1;
        call      = 1'b1;
        br_target = 11'h555;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk_b("stall_valid", instr_valid, 1'b1);
            chk_b("stall_req", imem_req, 1'b0);
            chk_v("stall_pc", pc, 11'h000);
        end
        stall    = 1'b0;
        br_taken = 1'b0;
        call     = 1'b0;
        step("after_stall", 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 11'h001, 1'b1);

        step("br_010", 1'b0, 1'b0, 1'b1, 1'b0, 11'h010, 11'h010, 1'b1);
        step("call_200", 1'b1, 1'b0, 1'b0, 1'b0, 11'h200, 11'h200, 1'b1);
        step("ret_011", 1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 11'h011, 1'b1);

        step("br_020", 1'b0, 1'b0, 1'b1, 1'b0, 11'h020, 11'h020, 1'b1);
        irq = 1'b1;
        step("irq_take", 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 11'h7F0, 1'b1);
        chk_b("irq_ack_on", irq_ack, 1'b1);
        irq = 1'b0;
        @(posedge clk);
        #1;
        chk_b("irq_ack_pulse", irq_ack, 1'b0);
        step("irq_ret", 1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 11'h021, 1'b1);

        // IRQ alongside a call is deferred to the following slot
        irq = 1'b1;
        step("call_defer", 1'b1, 1'b0, 1'b0, 1'b0, 11'h100, 11'h100, 1'b1);
        chk_b("defer_no_ack", irq_ack, 1'b0);
        step("irq_late", 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 11'h7F0, 1'b1);
        chk_b("defer_ack", irq_ack, 1'b1);
        irq = 1'b0;
        step("ret_101", 1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 11'h101, 1'b1);
        step("ret_022", 1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 11'h022, 1'b1);

        step("br_030", 1'b0, 1'b0, 1'b1, 1'b0, 11'h030, 11'h030, 1'b1);
        step("halt", 1'b0, 1'b0, 1'b0, 1'b1, 11'h000, 11'h031, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_b("halt_req", imem_req, 1'b0);
            chk_b("halt_valid", instr_valid, 1'b0);
            chk_v("halt_pc", pc, 11'h031);
        end
        exp_q.push_back(11'h031);
        resume = 1'b1;
        @(posedge clk);
        #1;
        resume = 1'b0;
        chk_b("resume_req", imem_req, 1'b1);

        // Five nested calls overflow a four-entry stack
        step("ncall1", 1'b1, 1'b0, 1'b0, 1'b0, 11'h300, 11'h300, 1'b1);
        step("ncall2", 1'b1, 1'b0, 1'b0, 1'b0, 11'h310, 11'h310, 1'b1);
        step("ncall3", 1'b1, 1'b0, 1'b0, 1'b0, 11'h320, 11'h320, 1'b1);
        step("ncall4", 1'b1, 1'b0, 1'b0, 1'b0, 11'h330, 11'h330, 1'b1);
        chk_b("full_no_err", rs_err, 1'b0);
        step("ncall5", 1'b1, 1'b0, 1'b0, 1'b0, 11'h340, 11'h340, 1'b1);
        chk_b("overflow_err", rs_err, 1'b1);
        step("nret1", 1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 11'h331, 1'b1);
        step("nret2", 1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 11'h321, 1'b1);
        step("nret3", 1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 11'h311, 1'b1);
        step("nret4", 1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 11'h301, 1'b1);
        step("underflow", 1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 11'h302, 1'b1);
        chk_b("sticky_err", rs_err, 1'b1);

        // Reset while parked in WAIT abandons the fetch
        wait_issue();
        imem_ack = 1'b0;
        step("park", 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 11'h303, 1'b1);
        @(posedge clk);
        #1;
        chk_b("park_req", imem_req, 1'b1);
        chk_v("park_addr", imem_addr, 11'h303);
        #2;
        rst_n = 1'b0;
        #1;
        chk_b("async_req", imem_req, 1'b0);
        chk_b("async_valid", instr_valid, 1'b0);
        chk_v("async_pc", pc, 11'h000);
        chk_b("async_rs_err", rs_err, 1'b0);
        exp_q.delete();
        imem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_b("late_ack_req", imem_req, 1'b0);
        exp_q.push_back(11'h000);
        rst_n = 1'b1;
        step("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 11'h001, 1'b1);
        wait_issue();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d fetches outstanding, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
